manchester_encoder: RTL and testbench

- Transmit-side Manchester encoder for the VLC link; drives the LED modulator line that the Manchester decoder samples, using the same clk16x domain.
- Accepts bytes over a valid/ready handshake and emits framed IEEE 802.3 Manchester (0 = high-to-low, 1 = low-to-high), LSB first.
- Frame format: high preamble, 3-half-bit low sync, back-to-back bytes.
- Between frames it drives a 50 % duty "PWM" idle pattern so LED brightness stays constant and the decoder recognises end-of-frame.

---
 rtl/manchester_encoder_if.sv | 10 +
 rtl/manchester_encoder.sv | 175 +++++++++++++++++
 tb/tb_manchester_encoder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/manchester_encoder_if.sv
// Byte handshake between a byte source and the Manchester encoder.
// A byte moves when in_valid and in_ready are both high at a clk16x rising edge.
interface manchester_encoder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/manchester_encoder.sv
// Transmit-side Manchester encoder for the VLC link.
// Frames are: high preamble, 3 low half-bits of sync, then back-to-back bytes
// (LSB first, 0 = high-to-low, 1 = low-to-high), then a bit-aligned 50 % idle
// pattern so LED brightness stays constant and the decoder sees end-of-frame.
module manchester_encoder #(
    parameter int HALF_BIT_CYCLES = 40,
    parameter int PREAMBLE_HB     = 4,
    parameter int GAP_PERIODS     = 5
) (
    input  logic                 clk16x,
    input  logic                 resetn,
    manchester_encoder_if.slave  inBus,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_end
);

    localparam int GAP_HB = GAP_PERIODS * 4;
    localparam int HB_MAX = (GAP_HB > PREAMBLE_HB) ? GAP_HB : PREAMBLE_HB;
    localparam int CNT_W  = $clog2(HB_MAX);
    localparam int HB_W   = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, GAP} state_t;

    state_t            state, stateNxt;
    logic [HB_W-1:0]   hbCnt;
    logic              hbTick;
    logic [1:0]        ph, phNxt;
    logic [CNT_W-1:0]  cnt, cntNxt;
    logic [7:0]        shift, shiftNxt;
    logic [2:0]        idx, idxNxt;
    logic              half, halfNxt;
    logic              txNxt;
    logic              feNxt;
    logic              load;
    logic [7:0]        hold;
    logic              holdFull;

    assign hbTick         = (hbCnt == HB_W'(HALF_BIT_CYCLES - 1));
    assign busy           = (state != IDLE);
    assign inBus.in_ready = ~holdFull;

    // Free-running half-bit timer; it never restarts so the grid cannot slip.
    always_ff @(posedge clk16x or negedge resetn) begin
        if (!resetn)     hbCnt <= '0;
        else if (hbTick) hbCnt <= '0;
        else             hbCnt <= hbCnt + HB_W'(1);
    end

    // One-byte holding register; loading into the shift register empties it.
    always_ff @(posedge clk16x or negedge resetn) begin
        if (!resetn) begin
            hold     <= '0;
            holdFull <= 1'b0;
        end else if (load) begin
            holdFull <= 1'b0;
        end else if (inBus.in_valid && !holdFull) begin
            hold     <= inBus.in_data;
            holdFull <= 1'b1;
        end
    end

    // Next half-bit slot: state, counters and the line level for that slot.
    always_comb begin
        stateNxt = state;
        phNxt    = ph;
        cntNxt   = cnt;
        shiftNxt = shift;
        idxNxt   = idx;
        halfNxt  = half;
        txNxt    = tx;
        feNxt    = 1'b0;
        load     = 1'b0;
        if (hbTick) begin
            case (state)
                IDLE: begin
                    if (ph == 2'd3 && holdFull) begin
                        stateNxt = PREAMBLE;
                        cntNxt   = '0;
                        txNxt    = 1'b1;
                    end else begin
                        phNxt = ph + 2'd1;
                        txNxt = ~phNxt[1];
                    end
                end
                PREAMBLE: begin
                    if (cnt == CNT_W'(PREAMBLE_HB - 1)) begin
                        stateNxt = SYNC;
                        cntNxt   = '0;
                        txNxt    = 1'b0;
                    end else begin
                        cntNxt = cnt + CNT_W'(1);
                        txNxt  = 1'b1;
                    end
                end
                SYNC: begin
                    if (cnt == CNT_W'(2)) begin
                        stateNxt = DATA;
                        load     = 1'b1;
                        shiftNxt = hold;
                        idxNxt   = '0;
                        halfNxt  = 1'b0;
                        txNxt    = ~hold[0];
                    end else begin
                        cntNxt = cnt + CNT_W'(1);
                        txNxt  = 1'b0;
                    end
                end
                DATA: begin
                    if (!half) begin
                        halfNxt = 1'b1;
                        txNxt   = shift[idx];
                    end else if (idx != 3'd7) begin
                        idxNxt  = idx + 3'd1;
                        halfNxt = 1'b0;
                        txNxt   = ~shift[idxNxt];
                    end else if (holdFull) begin
                        // Next byte already waiting: continue the frame seamlessly.
                        load     = 1'b1;
                        shiftNxt = hold;
                        idxNxt   = '0;
                        halfNxt  = 1'b0;
                        txNxt    = ~hold[0];
                    end else begin
                        stateNxt = GAP;
                        phNxt    = '0;
                        cntNxt   = '0;
                        txNxt    = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_HB - 1)) begin
                        stateNxt = IDLE;
                        phNxt    = '0;
                        txNxt    = 1'b1;
                        feNxt    = 1'b1;
                    end else begin
                        cntNxt = cnt + CNT_W'(1);
                        phNxt  = ph + 2'd1;
                        txNxt  = ~phNxt[1];
                    end
                end
                default: begin
                    stateNxt = IDLE;
                    phNxt    = '0;
                    txNxt    = 1'b1;
                end
            endcase
        end
    end

    // Registered state and line output; all slot changes land on hbTick.
    always_ff @(posedge clk16x or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ph        <= '0;
            cnt       <= '0;
            shift     <= '0;
            idx       <= '0;
            half      <= 1'b0;
            tx        <= 1'b1;
            frame_end <= 1'b0;
        end else begin
            state     <= stateNxt;
            ph        <= phNxt;
            cnt       <= cntNxt;
            shift     <= shiftNxt;
            idx       <= idxNxt;
            half      <= halfNxt;
            tx        <= txNxt;
            frame_end <= feNxt;
        end
    end

endmodule

// File: tb/tb_manchester_encoder.sv
// Bench for manchester_encoder: per-byte half-bit patterns come from a table,
// expected line levels are queued when a frame is offered and compared once
// per half-bit by a monitor sampling mid-half-bit.
module tb_manchester_encoder;

    localparam int HBC  = 40;
    localparam int PRE  = 4;
    localparam int GAPP = 5;

    logic clk16x = 1'b0;
    logic resetn = 1'b0;
    logic tx, busy, frame_end;

    manchester_encoder_if bus();

    manchester_encoder #(
        .HALF_BIT_CYCLES(HBC),
        .PREAMBLE_HB    (PRE),
        .GAP_PERIODS    (GAPP)
    ) dut (
        .clk16x   (clk16x),
        .resetn   (resetn),
        .inBus    (bus),
        .tx       (tx),
        .busy     (busy),
        .frame_end(frame_end)
    );

    always #5 clk16x = ~clk16x;

    // Byte plus its 16 half-bits in line order (bit 15 goes out first).
    typedef struct {
        logic [7:0]  d;
        logic [15:0] hb;
        bit          newFrame;
    } vec_t;
    vec_t vecs[11];

    int nChecks = 0;
    int nErrs   = 0;

    bit expQ[$];
    int lenQ[$];
    int inFrame = 0, curCnt = 0, curLen = -1;
    int feCnt = 0, idlePh = 0, idleRun = 0, lastIdleRun = 0;
    int framesDone = 0, readyFalls = 0;
    logic prevReady = 1'b1;
    int tbCnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Half-bit grid reference, aligned to reset release.
    always @(posedge clk16x or negedge resetn) begin
        if (!resetn) tbCnt <= 0;
        else         tbCnt <= (tbCnt == HBC - 1) ? 0 : tbCnt + 1;
    end

    // Monitor: per-cycle pulse counting and mid-half-bit line checks.
    initial begin
        forever begin
            @(negedge clk16x);
            if (resetn) begin
                if (frame_end) feCnt++;
                if (prevReady && !bus.in_ready) readyFalls++;
                prevReady = bus.in_ready;
                if (tbCnt == HBC / 2) begin
                    if (busy) begin
                        if (!inFrame) begin
                            inFrame     = 1;
                            curCnt      = 0;
                            lastIdleRun = idleRun;
                            if (lenQ.size() == 0) begin
                                curLen = -1;
                                check("unexpected_busy", busy, 0);
                            end else begin
                                curLen = lenQ.pop_front();
                            end
                        end
                        curCnt++;
                        if (expQ.size() > 0) check("frame_hb", tx, expQ.pop_front());
                        else if (curLen >= 0) check("frame_too_long", busy, 0);
                    end else begin
                        if (inFrame) begin
                            inFrame = 0;
                            if (curLen >= 0) check("frame_len", curCnt, curLen);
                            check("frame_end_pulses", feCnt, 1);
                            feCnt   = 0;
                            idlePh  = 0;
                            idleRun = 0;
                            framesDone++;
                        end
                        check("idle_tx", tx, (idlePh < 2) ? 1 : 0);
                        idlePh = (idlePh + 1) % 4;
                        idleRun++;
                    end
                end
            end else begin
                prevReady = 1'b1;
            end
        end
    end

    task automatic flushModel();
        expQ.delete();
        lenQ.delete();
        inFrame = 0; curCnt = 0; curLen = -1;
        feCnt = 0; idlePh = 0; idleRun = 0;
    endtask

    task automatic pushFrame(input int first, input int n);
        for (int p = 0; p < PRE; p++) expQ.push_back(1'b1);
        for (int s = 0; s < 3; s++)   expQ.push_back(1'b0);
        for (int b = first; b < first + n; b++)
            for (int h = 15; h >= 0; h--) expQ.push_back(vecs[b].hb[h]);
        for (int g = 0; g < GAPP * 4; g++) expQ.push_back((g % 4) < 2);
        lenQ.push_back(PRE + 3 + 16 * n + GAPP * 4);
    endtask

    task automatic sendByte(input logic [7:0] d);
        int k = 0;
        @(negedge clk16x);
        while (!bus.in_ready && k < 5000) begin
            @(negedge clk16x);
            k++;
        end
        check("send_ready", bus.in_ready, 1);
        if (bus.in_ready) begin
            bus.in_data  = d;
            bus.in_valid = 1'b1;
            @(negedge clk16x);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic waitFrames(input int target);
        int k = 0;
        while (framesDone < target && k < 20000) begin
            @(negedge clk16x);
            k++;
        end
        check("frame_done", framesDone, target);
    endtask

    task automatic waitInFrame(input int hbs);
        int k = 0;
        while (!(inFrame && curCnt >= hbs) && k < 20000) begin
            @(negedge clk16x);
            k++;
        end
        check("reach_half_bit", (inFrame && curCnt >= hbs) ? 1 : 0, 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, n, target;
        vecs[0]  = '{8'hA5, 16'h6699, 1'b1};
        vecs[1]  = '{8'h00, 16'hAAAA, 1'b1};
        vecs[2]  = '{8'hFF, 16'h5555, 1'b0};
        vecs[3]  = '{8'h3C, 16'hA55A, 1'b1};
        vecs[4]  = '{8'h81, 16'h6AA9, 1'b0};
        vecs[5]  = '{8'h7E, 16'h9556, 1'b0};
        vecs[6]  = '{8'h3C, 16'hA55A, 1'b1};
        vecs[7]  = '{8'h81, 16'h6AA9, 1'b0};
        vecs[8]  = '{8'h7E, 16'h9556, 1'b0};
        vecs[9]  = '{8'h01, 16'h6AAA, 1'b1};
        vecs[10] = '{8'hFF, 16'h5555, 1'b1};

        bus.in_data  = '0;
        bus.in_valid = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk16x);
        check("rst_tx", tx, 1);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_end", frame_end, 0);
        resetn = 1'b1;

        // Idle square wave is checked by the monitor.
        repeat (8 * HBC) @(negedge clk16x);

        // Table frames: single byte, back-to-back pair, two identical 3-byte frames.
        target = 0;
        i = 0;
        while (i < 9) begin
            n = 1;
            while (i + n < 9 && !vecs[i + n].newFrame) n++;
            pushFrame(i, n);
            readyFalls = 0;
            for (int j = 0; j < n; j++) sendByte(vecs[i + j].d);
            target++;
            waitFrames(target);
            if (n == 2) check("ready_falls_pair", readyFalls, 2);
            i += n;
        end

        // Byte offered during GAP waits for the gap and the next ph 3 boundary.
        pushFrame(9, 1);
        sendByte(vecs[9].d);
        waitInFrame(PRE + 3 + 16 + 2);
        check("busy_in_gap", busy, 1);
        pushFrame(10, 1);
        sendByte(vecs[10].d);
        check("gap_byte_held", bus.in_ready, 0);
        target += 2;
        waitFrames(target);
        check("gap_idle_run", lastIdleRun, 4);

        // Reset in the middle of DATA bit 3 with a second byte held.
        pushFrame(0, 1);
        sendByte(vecs[0].d);
        waitInFrame(1);
        sendByte(8'h5A);
        waitInFrame(PRE + 3 + 7);
        repeat (5) @(negedge clk16x);
        check("pre_rst_held", bus.in_ready, 0);
        resetn = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_busy", busy, 0);
        flushModel();
        repeat (3) @(negedge clk16x);
        resetn = 1'b1;
        repeat (20 * HBC) @(negedge clk16x);
        check("post_rst_busy", busy, 0);
        check("post_rst_in_ready", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
        $finish;
    end

endmodule
